// File: rtl/reset_gen_pkg.sv
// Shared types and helpers for the reset pulse generator.
package reset_gen_pkg;

    localparam int CNTW_DEF = 8;

    typedef enum logic [1:0] {
        ST_POR,
        ST_HOLD,
        ST_GAP,
        ST_IDLE
    } state_t;

    // Requested assertion width: an explicit non-zero HOLD_CYCLES wins, zero falls back to RSTHOLD.
    function automatic logic [31:0] sel_hold_len(input logic [31:0] hold_cycles,
                                                 input logic [31:0] rsthold);
        return (hold_cycles != 32'd0) ? hold_cycles : rsthold;
    endfunction

endpackage

// File: rtl/reset_hold_counter.sv
// Loadable down-counter with zero flag; clears asynchronously to INIT.
module reset_hold_counter #(
    parameter int              CNTW = 8,
    parameter logic [CNTW-1:0] INIT = '0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            load,
    input  logic            dec,
    input  logic [CNTW-1:0] load_val,
    output logic            zero
);

    logic [CNTW-1:0] count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= INIT;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNTW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/reset_pulse_gen.sv
// Source-side reset generator: async assert, sync release, programmable width.
// Optional RESET_PULSE_GEN_EXTEND_EN: requests during HOLD reload and stretch the pulse.
module reset_pulse_gen
    import reset_gen_pkg::*;
#(
    parameter int RSTHOLD = 4,
    parameter int CNTW    = CNTW_DEF,
    parameter int GAP     = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            ASSERT_REQ,
    input  logic [CNTW-1:0] HOLD_CYCLES,
    output logic            REQ_RDY,
    output logic            OUT_RST_N,
    output logic            ASSERTED,
    output logic            DONE
);

    localparam logic [CNTW-1:0] RSTHOLD_INIT = CNTW'(RSTHOLD);
    localparam logic [CNTW-1:0] RSTHOLD_M1   = CNTW'(RSTHOLD - 1);
    localparam logic [CNTW-1:0] GAP_M1       = (GAP > 0) ? CNTW'(GAP - 1) : '0;
`ifdef RESET_PULSE_GEN_EXTEND_EN
    localparam bit EXTEND_EN = 1'b1;
`else
    localparam bit EXTEND_EN = 1'b0;
`endif

    state_t          state_q, state_d;
    logic            out_rst_n_q, out_rst_n_d;
    logic            asserted_q, asserted_d;
    logic            done_q, done_d;
    logic            req_rdy;
    logic            hold_load, hold_dec, hold_zero;
    logic            gap_load, gap_dec, gap_zero;
    logic [CNTW-1:0] hold_load_val;
    logic [CNTW-1:0] req_len_m1;

    assign req_len_m1 = CNTW'(sel_hold_len(32'(HOLD_CYCLES), 32'(RSTHOLD)) - 32'd1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_POR;
            out_rst_n_q <= 1'b0;
            asserted_q  <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_rst_n_q <= out_rst_n_d;
            asserted_q  <= asserted_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        out_rst_n_d   = out_rst_n_q;
        asserted_d    = asserted_q;
        done_d        = 1'b0;
        req_rdy       = 1'b0;
        hold_load     = 1'b0;
        hold_dec      = 1'b0;
        hold_load_val = req_len_m1;
        gap_load      = 1'b0;
        gap_dec       = 1'b0;
        case (state_q)
            ST_POR: begin
                state_d       = ST_HOLD;
                hold_load     = 1'b1;
                hold_load_val = RSTHOLD_M1;
                out_rst_n_d   = 1'b0;
                asserted_d    = 1'b1;
            end
            ST_HOLD: begin
                req_rdy = EXTEND_EN;
                if (EXTEND_EN && ASSERT_REQ) begin
                    hold_load = 1'b1;
                end else if (hold_zero) begin
                    // Release edge: the only place OUT_RST_N goes high, always on CLK.
                    out_rst_n_d = 1'b1;
                    asserted_d  = 1'b0;
                    done_d      = 1'b1;
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_GAP;
                        gap_load = 1'b1;
                    end
                end else begin
                    hold_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            ST_IDLE: begin
                req_rdy = 1'b1;
                if (ASSERT_REQ) begin
                    state_d     = ST_HOLD;
                    hold_load   = 1'b1;
                    out_rst_n_d = 1'b0;
                    asserted_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_POR;
            end
        endcase
    end

    reset_hold_counter #(.CNTW(CNTW), .INIT(RSTHOLD_INIT)) u_hold_cnt (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (hold_load),
        .dec      (hold_dec),
        .load_val (hold_load_val),
        .zero     (hold_zero)
    );

    reset_hold_counter #(.CNTW(CNTW), .INIT('0)) u_gap_cnt (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (gap_load),
        .dec      (gap_dec),
        .load_val (GAP_M1),
        .zero     (gap_zero)
    );

    assign REQ_RDY   = req_rdy;
    assign OUT_RST_N = out_rst_n_q;
    assign ASSERTED  = asserted_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Directed bench for reset_pulse_gen: a width scoreboard fed by stimulus, drained by a pulse monitor.
module tb_reset_pulse_gen;

    localparam int RSTHOLD = 4;
    localparam int CNTW    = 8;
    localparam int GAP     = 2;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b1;
    logic            ASSERT_REQ = 1'b0;
    logic [CNTW-1:0] HOLD_CYCLES = '0;
    logic            REQ_RDY, OUT_RST_N, ASSERTED, DONE;

    int vectors = 0;
    int miscompares = 0;
    int exp_w[$];
    int exp_done = 0;
    int rd = 0;

    // Monitor-owned observations: one entry per completed low pulse outside reset.
    int obs_w[64];
    int obs_d[64];
    int obs_g[64];
    int obs_n = 0;
    int low_run = 0;
    int high_run = 0;
    int gap_before = 0;
    int done_total = 0;
    int asrt_bad = 0;

    always #5 CLK = ~CLK;

    reset_pulse_gen #(.RSTHOLD(RSTHOLD), .CNTW(CNTW), .GAP(GAP)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .ASSERT_REQ  (ASSERT_REQ),
        .HOLD_CYCLES (HOLD_CYCLES),
        .REQ_RDY     (REQ_RDY),
        .OUT_RST_N   (OUT_RST_N),
        .ASSERTED    (ASSERTED),
        .DONE        (DONE)
    );

    always @(negedge CLK) begin
        if (!RST_N) begin
            low_run  <= 0;
            high_run <= 0;
        end else if (OUT_RST_N === 1'b0) begin
            low_run <= low_run + 1;
            if (low_run == 0) begin
                gap_before <= high_run;
                high_run   <= 0;
            end
        end else begin
            high_run <= high_run + 1;
            if (low_run != 0 && obs_n < 64) begin
                obs_w[obs_n] <= low_run;
                obs_d[obs_n] <= int'(DONE);
                obs_g[obs_n] <= gap_before;
                obs_n        <= obs_n + 1;
                low_run      <= 0;
            end
        end
        if (DONE === 1'b1) done_total <= done_total + 1;
        if (ASSERTED !== ~OUT_RST_N) asrt_bad <= asrt_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic push_pulse(input int w);
        exp_w.push_back(w);
        exp_done++;
    endtask

    task automatic wait_pulse(input string tag, input int exp_gap);
        int n = 0;
        int w;
        while (obs_n <= rd && n < 400) begin
            nclk(1);
            n++;
        end
        w = exp_w.pop_front();
        check({tag, "_seen"}, 32'(obs_n > rd), 32'd1);
        if (obs_n > rd) begin
            check({tag, "_width"}, obs_w[rd], w);
            check({tag, "_done"}, obs_d[rd], 32'd1);
            if (exp_gap >= 0) check({tag, "_gap"}, obs_g[rd], exp_gap);
            rd++;
        end
    endtask

    task automatic wait_rdy(input string tag, output int cycles);
        cycles = 0;
        while (REQ_RDY !== 1'b1 && cycles < 400) begin
            nclk(1);
            cycles++;
        end
        check({tag, "_rdy"}, 32'(REQ_RDY), 32'd1);
    endtask

    task automatic request(input int hold);
        HOLD_CYCLES = CNTW'(hold);
        ASSERT_REQ  = 1'b1;
        nclk(1);
        ASSERT_REQ  = 1'b0;
    endtask

    initial begin
        int c;
        int d0;
        int n_before;

        // Test 1: power-up reset
        #2 RST_N = 1'b0;
        #1;
        check("por_async_out", 32'(OUT_RST_N), 32'd0);
        check("por_async_asserted", 32'(ASSERTED), 32'd1);
        check("por_async_rdy", 32'(REQ_RDY), 32'd0);
        check("por_async_done", 32'(DONE), 32'd0);
        nclk(3);
        check("por_held_out", 32'(OUT_RST_N), 32'd0);
        check("por_held_done", 32'(DONE), 32'd0);
        push_pulse(RSTHOLD);
        RST_N = 1'b1;
        wait_pulse("por", -1);
        wait_rdy("por", c);
        check("por_gap_len", c, GAP);

        // Test 2: explicit width, HOLD_CYCLES changes after acceptance are ignored
        push_pulse(7);
        request(7);
        HOLD_CYCLES = 8'd3;
        check("req7_out_low", 32'(OUT_RST_N), 32'd0);
        check("req7_asserted", 32'(ASSERTED), 32'd1);
        c = 0;
        while (REQ_RDY !== 1'b1 && c < 100) begin
            c++;
            nclk(1);
        end
`ifdef RESET_PULSE_GEN_EXTEND_EN
        check("req7_rdy_low", c, 0);
`else
        check("req7_rdy_low", c, 7 + GAP);
`endif
        wait_pulse("req7", -1);
        wait_rdy("req7", c);

        // Test 3: width selection corners
        push_pulse(RSTHOLD);
        request(0);
        wait_pulse("req0", -1);
        wait_rdy("req0", c);
        push_pulse(1);
        request(1);
        wait_pulse("req1", -1);
        wait_rdy("req1", c);
        push_pulse(255);
        request(255);
        wait_pulse("req255", -1);
        wait_rdy("req255", c);

`ifndef RESET_PULSE_GEN_EXTEND_EN
        // Test 4: request held high gives separated pulses, never merged
        push_pulse(3);
        push_pulse(3);
        push_pulse(3);
        HOLD_CYCLES = 8'd3;
        ASSERT_REQ  = 1'b1;
        wait_pulse("hold_a", -1);
        wait_pulse("hold_b", GAP + 1);
        wait_pulse("hold_c", GAP + 1);
        ASSERT_REQ = 1'b0;
        wait_rdy("hold", c);
        nclk(3);
        check("hold_no_extra", obs_n, rd);
        check("hold_out_high", 32'(OUT_RST_N), 32'd1);
`endif

        // Test 5: reset abort in the middle of a 10-cycle pulse
        request(10);
        nclk(2);
        d0 = done_total;
        #1 RST_N = 1'b0;
        #1;
        check("abort_out", 32'(OUT_RST_N), 32'd0);
        check("abort_asserted", 32'(ASSERTED), 32'd1);
        check("abort_rdy", 32'(REQ_RDY), 32'd0);
        nclk(2);
        push_pulse(RSTHOLD);
        RST_N = 1'b1;
        wait_pulse("abort", -1);
        check("abort_done_once", done_total, d0 + 1);
        wait_rdy("abort", c);

        // Test 5b: asynchronous assertion straight out of IDLE
        #1 RST_N = 1'b0;
        #1;
        check("idle_async_out", 32'(OUT_RST_N), 32'd0);
        check("idle_async_asserted", 32'(ASSERTED), 32'd1);
        check("idle_async_rdy", 32'(REQ_RDY), 32'd0);
        nclk(2);
        push_pulse(RSTHOLD);
        RST_N = 1'b1;
        wait_pulse("idle_rst", -1);
        wait_rdy("idle_rst", c);

        // Test 6: second request three cycles into a 5-cycle pulse
`ifdef RESET_PULSE_GEN_EXTEND_EN
        push_pulse(8);
`else
        push_pulse(5);
`endif
        request(5);
        nclk(1);
`ifdef RESET_PULSE_GEN_EXTEND_EN
        check("ext_rdy_in_hold", 32'(REQ_RDY), 32'd1);
`else
        check("ext_rdy_in_hold", 32'(REQ_RDY), 32'd0);
`endif
        nclk(1);
        request(5);
        wait_pulse("ext", -1);
        wait_rdy("ext", c);
        n_before = obs_n;
        nclk(4);
        check("ext_no_queued", obs_n, n_before);

        check("asserted_tracks_out", asrt_bad, 0);
        check("done_total", done_total, exp_done);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
